// File: rtl/clkset_pkg.sv
// Shared clock-control constants: CLKSET field positions and controller state encoding.
package clkset_pkg;

  localparam int CLK_CFG_W      = 7;
  localparam int CLK_RESET_BIT  = 7;
  localparam int CLK_PLLENA_BIT = 6;
  localparam int CLK_OSCENA_BIT = 5;
  localparam int CLK_OSCM_LO    = 3;
  localparam int CLK_CLKSEL_HI  = 2;
  localparam int CLK_CLKSEL_LO  = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } clk_state_e;

endpackage

// File: rtl/clk_settle.sv
// Reusable 16-bit settle timer: load a wait, count down to zero, flag the last cycle.
module clk_settle (
  input  logic        clk,
  input  logic        res,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value,
  output logic        done
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Saturates at zero so an idle timer never wraps.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != 16'd0) begin
      value_d = value_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      value_q <= 16'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign done  = (value_q == 16'd1);

endmodule

// File: rtl/clkset.sv
// CLKSET register: commits clock configuration, holding CLKSEL back while a newly
// enabled oscillator or PLL settles.
module clkset
  import clkset_pkg::*;
#(
  parameter logic [15:0] OSC_WAIT = 16'd1000,
  parameter logic [15:0] PLL_WAIT = 16'd100
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 wr,
  input  logic [7:0]           wdata,
  output logic [CLK_CFG_W-1:0] cfg,
  output logic                 busy,
  output logic                 soft_res,
  output logic [7:0]           rd
);

  clk_state_e                   state_q, state_d;
  logic [CLK_CFG_W-1:0]         cfg_q, cfg_d;
  logic [CLK_CLKSEL_HI:0]       pend_q, pend_d;
  logic                         soft_q, soft_d;
  logic                         cnt_load;
  logic [15:0]                  cnt_load_val;
  logic [15:0]                  cnt_value;
  logic                         cnt_done;
  logic                         osc_rise;
  logic                         pll_rise;

  clk_settle u_settle (
    .clk      (clk),
    .res      (res),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .done     (cnt_done)
  );

  assign osc_rise = wdata[CLK_OSCENA_BIT] & ~cfg_q[CLK_OSCENA_BIT];
  assign pll_rise = wdata[CLK_PLLENA_BIT] & ~cfg_q[CLK_PLLENA_BIT];

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    pend_d       = pend_q;
    soft_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = 16'd0;
    unique case (state_q)
      ST_IDLE: begin
        // An idle timer always reads zero; the check keeps a stray count from reopening a settle.
        if (wr && (cnt_value == 16'd0)) begin
          if (wdata[CLK_RESET_BIT]) begin
            soft_d = 1'b1;
          end else if (osc_rise || pll_rise) begin
            cfg_d        = {wdata[CLK_PLLENA_BIT:CLK_OSCM_LO], cfg_q[CLK_CLKSEL_HI:CLK_CLKSEL_LO]};
            pend_d       = wdata[CLK_CLKSEL_HI:CLK_CLKSEL_LO];
            cnt_load     = 1'b1;
            cnt_load_val = osc_rise ? OSC_WAIT : PLL_WAIT;
            state_d      = ST_SETTLE;
          end else begin
            cfg_d = wdata[CLK_CFG_W-1:0];
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_done) begin
          cfg_d[CLK_CLKSEL_HI:CLK_CLKSEL_LO] = pend_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      pend_q  <= '0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pend_q  <= pend_d;
      soft_q  <= soft_d;
    end
  end

  assign cfg      = cfg_q;
  assign busy     = (state_q == ST_SETTLE);
  assign soft_res = soft_q;
  assign rd       = {1'b0, cfg_q};

endmodule

// File: doc/clkset.md
CLKSET -- requirements
Module: clkset

Interface
REQ-001 The block SHALL have parameter OSC_WAIT, default 16'd1000, meaning cycles to hold CLKSEL after the oscillator enable rises.
REQ-002 The block SHALL have parameter PLL_WAIT, default 16'd100, meaning cycles to hold CLKSEL after the PLL enable rises alone; OSC_WAIT >= PLL_WAIT >= 1.
REQ-003 The block SHALL have port clk  input  1  system clock; it is the only clock.
REQ-004 The block SHALL have port res  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port wr  input  1  CLKSET write strobe from hub, one cycle.
REQ-006 The block SHALL have port wdata  input  8  written value: [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
REQ-007 The block SHALL have port cfg  output  7  configuration driven to the clock divider stage, same bit order as wdata[6:0].
REQ-008 The block SHALL have port busy  output  1  settle in progress; writes ignored.
REQ-009 The block SHALL have port soft_res  output  1  one-cycle chip reset request.
REQ-010 The block SHALL have port rd  output  8  readback, {1'b0, cfg}.

Function
REQ-011 States SHALL be IDLE and SETTLE; busy = (state == SETTLE).
REQ-012 A write is accepted only when wr=1 in IDLE; wr in SETTLE SHALL be dropped with no effect.
REQ-013 Accepted write with wdata[7]=1 SHALL assert soft_res for exactly the next cycle, leave cfg unchanged, and stay IDLE.
REQ-014 Accepted write with wdata[7]=0: osc_rise = wdata[5] & ~cfg[5]; pll_rise = wdata[6] & ~cfg[6].
REQ-015 If neither rises, cfg SHALL equal wdata[6:0] on the next cycle (latency 1), state stays IDLE.
REQ-016 If either rises, the next cycle SHALL drive cfg = {wdata[6:3], cfg[2:0]}, latch pending CLKSEL = wdata[2:0], load counter with OSC_WAIT if osc_rise else PLL_WAIT, enter SETTLE.
REQ-017 In SETTLE the 16-bit counter SHALL decrement by 1 per cycle; in the cycle it reads 1, cfg[2:0] SHALL be loaded from pending on the following edge and state returns to IDLE.
REQ-018 Hence CLKSEL changes exactly W+1 cycles after the wr cycle (W = selected wait), and busy is high for exactly W cycles.
REQ-019 The counter SHALL never wrap; it holds 0 in IDLE.
REQ-020 Enables falling with no enable rising SHALL commit in one cycle together with CLKSEL (REQ-015).
REQ-021 Writing a value equal to cfg SHALL be a one-cycle no-op with busy staying low.
REQ-022 soft_res SHALL be low in every cycle except the one after an accepted RESET write.

Reset
REQ-023 While res=1 on an edge: cfg=7'b0000000 (RCFAST, oscillator and PLL off), state=IDLE, counter=0, pending=0, soft_res=0; wr is ignored.
REQ-024 res asserted mid-SETTLE SHALL abort the settle; pending CLKSEL is discarded.
REQ-025 Outputs SHALL be valid reset values in the first cycle after res deasserts.

Structure
REQ-026 Bit positions of CLK fields (RESET, PLLENA, OSCENA, OSCM, CLKSEL) and state encodings SHALL live in a shared clock-constants include used by this block and the clock divider.
REQ-027 The wait counter SHALL be a sub-module clk_settle (load, value, done) so later blocks can reuse it.
REQ-028 All outputs SHALL be registered; no combinational path from wr/wdata to cfg.

Verification (OSC_WAIT=20, PLL_WAIT=8)
REQ-029 Reset, then wr wdata=8'h01 -> cfg=7'h01 one cycle later, busy never high.
REQ-030 From cfg=7'h00, wr 8'h6F -> cfg=7'h68 next cycle, busy high 20 cycles, cfg=7'h6F at wr+21.
REQ-031 From cfg=7'h68, wr 8'h6F -> cfg=7'h6F next cycle, no settle (no enable rises); from cfg=7'h28, wr 8'h6B -> busy for 8 cycles, cfg=7'h6B at wr+9.
REQ-032 During REQ-030 settle, wr 8'h01 at busy cycle 5 -> ignored, final cfg=7'h6F.
REQ-033 wr 8'h80 -> soft_res high exactly one cycle, cfg unchanged; res at busy cycle 10 -> cfg=7'h00, busy=0 next cycle.
